pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL wrapper and is clocked by its PLLOUTCORE output (25.125 MHz).
- Synchronises the asynchronous PLL `locked` flag and waits for lock to be continuously stable for a programmable time.
- Only then releases the synchronous system reset to the RFID reader core.
- Also provides a one-cycle timebase strobe for baseband timing and records lock-loss events.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `locked` synchroniser; must be >= 2.
- LOCK_CYCLES, 1024, consecutive synchronised-locked cycles required before reset release; must be >= 1.
- TICK_DIV, 25, period of `tick` in clock_in cycles; must be >= 1.
- LOSS_CNT_W, 4, width of the lock-loss counter.

Ports:
- clock_in, input, 1, PLL output clock; the only clock in this block.
- reset, input, 1, synchronous, active-high reset.
- locked, input, 1, raw PLL lock flag; asynchronous to clock_in.
- sys_reset, output, 1, active-high synchronous reset for downstream logic.
- ready, output, 1, high when the sequencer is in RUN; always equals !sys_reset.
- tick, output, 1, one-cycle strobe every TICK_DIV cycles while in RUN.
- lock_lost, output, 1, sticky flag: lock dropped at least once while in RUN.
- loss_count, output, LOSS_CNT_W, number of RUN-to-HOLD lock drops; saturates at all-ones.

Behaviour:
- Reset (reset=1 sampled at an edge, in any state):
  - state=HOLD, synchroniser flops=0, lock counter=0, tick divider=0.
  - Outputs: sys_reset=1, ready=0, tick=0, lock_lost=0, loss_count=0.
  - Reset overrides every other event in the same cycle.
- Synchroniser:
  - SYNC_STAGES-deep flop chain produces `locked_s`.
  - A raw rise sampled at edge e makes locked_s high after edge e+SYNC_STAGES-1.
  - No other logic samples raw `locked`.
- FSM states, all transitions registered:
  - HOLD: sys_reset=1. If locked_s=1, go to ARM and set cnt=0.
  - ARM: sys_reset=1.
    - If locked_s=0, go to HOLD and set cnt=0 (the stability window restarts from zero).
    - Else if cnt==LOCK_CYCLES-1, go to RUN.
    - Else cnt+1.
  - RUN: sys_reset=0, ready=1. If locked_s=0, go to HOLD, set lock_lost=1, and increment loss_count unless it is already all-ones.
- Release latency: with `locked` rising and held from edge e, sys_reset falls after edge e+SYNC_STAGES+LOCK_CYCLES.
- Reassertion latency: on a lock drop in RUN sampled at edge e, sys_reset returns high after edge e+SYNC_STAGES.
- Lock counter width: clog2(LOCK_CYCLES+1). It never wraps.
- Tick divider:
  - Counts 0..TICK_DIV-1 only while in RUN, wraps to 0, and is held at 0 in HOLD and ARM.
  - tick = (state==RUN && div==TICK_DIV-1), decoded from registers only.
  - First tick occurs in RUN cycle TICK_DIV-1 (the first RUN cycle is cycle 0).
  - TICK_DIV=1: tick is continuously high in RUN.
- Lock-loss recording:
  - lock_lost and loss_count change only on a RUN-to-HOLD drop.
  - A drop during ARM does not count.
  - Both are cleared only by `reset`.
- Glitches: a `locked` pulse shorter than one clock may be missed. Any low sample of locked_s in ARM or RUN must be honoured.

Test Plan:
1. LOCK_CYCLES=8, TICK_DIV=4, SYNC_STAGES=2; deassert reset, raise `locked` before edge 10 and hold it -> sys_reset=1 through edge 19 and falls after edge 20; ready rises at the same edge; first tick in the 4th RUN cycle, then every 4 cycles.
2. Same parameters; `locked` high for 5 cycles, low for 2 cycles, then high again -> sequencer returns to HOLD, cnt restarts; sys_reset falls exactly 10 edges after the second rise; lock_lost=0, loss_count=0.
3. In RUN, drop `locked` for 3 cycles and then restore it -> sys_reset high 2 edges after the drop; tick stops and the divider is cleared; lock_lost=1, loss_count=1; full re-arm of 10 edges after restore.
4. LOSS_CNT_W=2; cause 5 RUN lock drops -> loss_count goes 1,2,3,3,3 and never wraps.
5. Assert reset for one cycle while in RUN with `locked` held high -> next edge gives sys_reset=1, lock_lost=0, loss_count=0, state HOLD; re-release occurs after SYNC_STAGES+LOCK_CYCLES+… per the latency rule, with no tick while not in RUN.
6. TICK_DIV=1, LOCK_CYCLES=1 -> sys_reset falls 3 edges after the `locked` rise; tick is continuously high for every RUN cycle.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Holds the downstream system in reset until the PLL has reported lock
// continuously for LOCK_CYCLES synchronised cycles, then releases it.
// While running it provides a periodic one-cycle timebase strobe.
// It also records every occasion on which lock was lost after release.
//
// Ports
//   clock_in   : PLL output clock, the only clock of this block
//   reset      : synchronous, active-high reset
//   locked     : raw PLL lock flag, asynchronous to clock_in
//   sys_reset  : active-high synchronous reset for downstream logic
//   ready      : high while running, always the inverse of sys_reset
//   tick       : one-cycle strobe every TICK_DIV cycles while running
//   lock_lost  : sticky, lock dropped at least once while running
//   loss_count : number of running-to-hold lock drops, saturating
//
// Parameters
//   SYNC_STAGES : depth of the locked synchroniser (>= 2)
//   LOCK_CYCLES : consecutive locked cycles required before release (>= 1)
//   TICK_DIV    : tick period in clock cycles (>= 1)
//   LOSS_CNT_W  : width of loss_count
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int TICK_DIV    = 25,
    parameter int LOSS_CNT_W  = 4
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  locked,
    output logic                  sys_reset,
    output logic                  ready,
    output logic                  tick,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    // The lock counter only has to reach LOCK_CYCLES-1, so this width never wraps.
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    // A divider of period one still needs a one-bit register to stay legal.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [CNT_W-1:0]      cnt_next;
    logic [DIV_W-1:0]      div_reg;
    logic [DIV_W-1:0]      div_next;
    logic                  lost_reg;
    logic                  lost_next;
    logic [LOSS_CNT_W-1:0] loss_reg;
    logic [LOSS_CNT_W-1:0] loss_next;

    // -----------------------------------------------------------------------
    // Synchroniser: the only place the raw locked flag is sampled.
    // Bit 0 captures the asynchronous input; the top bit is locked_s.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   locked_s;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_reg[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
            div_reg   <= '0;
            lost_reg  <= 1'b0;
            loss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            div_reg   <= div_next;
            lost_reg  <= lost_next;
            loss_reg  <= loss_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. The tick divider defaults to zero so it is held
    // cleared everywhere except while remaining in RUN.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        div_next   = '0;
        lost_next  = lost_reg;
        loss_next  = loss_reg;

        case (state_reg)
            ST_HOLD: begin
                cnt_next = '0;
                if (locked_s) begin
                    state_next = ST_ARM;
                end
            end

            ST_ARM: begin
                if (!locked_s) begin
                    // Any low sample restarts the stability window from zero.
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    lost_next  = 1'b1;
                    if (!(&loss_reg)) begin
                        loss_next = loss_reg + LOSS_CNT_W'(1);
                    end
                end else if (div_reg == DIV_LAST) begin
                    div_next = '0;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end

            default: begin
                state_next = ST_HOLD;
                cnt_next   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registers only
    // -----------------------------------------------------------------------
    assign ready      = (state_reg == ST_RUN);
    assign sys_reset  = !ready;
    assign tick       = ready && (div_reg == DIV_LAST);
    assign lock_lost  = lost_reg;
    assign loss_count = loss_reg;

endmodule
